// File: rtl/axis_rr_packet_arbiter_if.sv
// axis_rr_packet_arbiter_if: N slave AXI-Stream ports and one master port shared by the arbiter.
// slave is the arbiter's view; master is the view of whatever drives the producers and the sink.
interface axis_rr_packet_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_REQ-1:0]            s_axis_tvalid;
    logic [NUM_REQ-1:0]            s_axis_tlast;
    logic [NUM_REQ-1:0]            s_axis_tready;
    logic [DATA_WIDTH-1:0]         m_axis_tdata;
    logic                          m_axis_tvalid;
    logic                          m_axis_tlast;
    logic [ID_WIDTH-1:0]           m_axis_tid;
    logic                          m_axis_tready;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tid
    );
endinterface

// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter: round-robin N:1 AXI-Stream arbiter that holds each grant until tlast.
// Forwarding is purely combinational while LOCKED; one IDLE cycle separates packets.
module axis_rr_packet_arbiter #(
    parameter int  NUM_REQ    = 4,
    parameter int  DATA_WIDTH = 64,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                   aclk,
    input  logic                   areset,
    axis_rr_packet_arbiter_if.slave axis,
    output logic                   grant_active,
    output logic [ID_WIDTH-1:0]    grant_idx
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] rr_q, rr_d;
    logic [ID_WIDTH-1:0] pick;
    logic                found;
    logic                locked;
    logic                pkt_end;

    assign locked       = (state_q == LOCKED);
    assign grant_active = locked;
    assign grant_idx    = grant_q;

    assign axis.m_axis_tdata  = axis.s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
    assign axis.m_axis_tvalid = locked & axis.s_axis_tvalid[grant_q];
    assign axis.m_axis_tlast  = locked & axis.s_axis_tlast[grant_q];
    assign axis.m_axis_tid    = grant_q;
    assign axis.s_axis_tready = locked ? (NUM_REQ'(axis.m_axis_tready) << grant_q) : '0;
    assign pkt_end            = axis.m_axis_tvalid & axis.m_axis_tready & axis.m_axis_tlast;

    // first valid requester searching cyclically from rr_q
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && axis.s_axis_tvalid[(int'(rr_q) + k) % NUM_REQ]) begin
                pick  = ID_WIDTH'((int'(rr_q) + k) % NUM_REQ);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        if (!locked && found) begin
            state_d = LOCKED;
            grant_d = pick;
        end
        if (locked && pkt_end) begin
            state_d = IDLE;
            rr_d    = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end
endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// tb_axis_rr_packet_arbiter: vector table, directed packet sequences and a randomized run
// compared against a behavioural model of the round-robin packet arbiter.
module tb_axis_rr_packet_arbiter;
    localparam int N  = 4;
    localparam int DW = 64;

    logic       aclk = 1'b0;
    logic       areset;
    logic       grant_active;
    logic [1:0] grant_idx;
    int         n_chk = 0;
    int         n_fail = 0;

    axis_rr_packet_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW)) axis ();

    axis_rr_packet_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .axis         (axis.slave),
        .grant_active (grant_active),
        .grant_idx    (grant_idx)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       rst_n;
        logic [3:0] vld;
        logic [3:0] lst;
        logic       rdy;
        logic       e_mv;
        logic       e_ml;
        int         e_tid;
        logic       e_act;
        logic [3:0] e_sr;
    } vec_t;

    vec_t tbl[22];

    function automatic logic [63:0] dat(input int i, input int b);
        return {32'hDA7A0000 | 32'(i), 32'(b)};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic emv, input logic eml, input int etid,
                           input logic eact, input logic [3:0] esr, input logic [63:0] edat);
        chk({nm, " m_tvalid"}, 64'(axis.m_axis_tvalid), 64'(emv));
        if (emv) begin
            chk({nm, " m_tlast"}, 64'(axis.m_axis_tlast), 64'(eml));
            chk({nm, " m_tdata"}, axis.m_axis_tdata, edat);
        end
        chk({nm, " m_tid"}, 64'(axis.m_axis_tid), 64'(etid));
        chk({nm, " grant_idx"}, 64'(grant_idx), 64'(etid));
        chk({nm, " grant_active"}, 64'(grant_active), 64'(eact));
        chk({nm, " s_tready"}, 64'(axis.s_axis_tready), 64'(esr));
    endtask

    task automatic drive(input logic rst_n, input logic [3:0] vld, input logic [3:0] lst,
                         input logic rdy, input int b0, input int b1, input int b2, input int b3);
        int b[4];
        b = '{b0, b1, b2, b3};
        areset             = rst_n;
        axis.s_axis_tvalid = vld;
        axis.s_axis_tlast  = lst;
        axis.m_axis_tready = rdy;
        for (int i = 0; i < N; i++) axis.s_axis_tdata[DW*i +: DW] = dat(i, b[i]);
    endtask

    task automatic do_reset();
        drive(1'b0, 4'h0, 4'h0, 1'b1, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int owner, ptr, lastg;
        int beats[4];
        int b2, k;
        logic emv, eml;
        logic [3:0] vld, lst, esr;
        logic rdy, rst_n;

        tbl[0]  = '{1'b0, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[2]  = '{1'b1, 4'hF, 4'h1, 1'b1, 1'b1, 1'b1, 0, 1'b1, 4'h1};
        tbl[3]  = '{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[4]  = '{1'b1, 4'h8, 4'h8, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[5]  = '{1'b1, 4'h8, 4'h8, 1'b1, 1'b1, 1'b1, 3, 1'b1, 4'h8};
        tbl[6]  = '{1'b1, 4'h9, 4'h9, 1'b1, 1'b0, 1'b0, 3, 1'b0, 4'h0};
        tbl[7]  = '{1'b1, 4'h9, 4'h9, 1'b1, 1'b1, 1'b1, 0, 1'b1, 4'h1};
        tbl[8]  = '{1'b1, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[9]  = '{1'b1, 4'h4, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[10] = '{1'b1, 4'h6, 4'h4, 1'b0, 1'b1, 1'b1, 2, 1'b1, 4'h0};
        tbl[11] = '{1'b1, 4'h6, 4'h4, 1'b1, 1'b1, 1'b1, 2, 1'b1, 4'h4};
        tbl[12] = '{1'b1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 4'h0};
        tbl[13] = '{1'b1, 4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 1, 1'b1, 4'h2};
        tbl[14] = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 4'h2};
        tbl[15] = '{1'b1, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 1, 1'b1, 4'h2};
        tbl[16] = '{1'b1, 4'h3, 4'h2, 1'b1, 1'b1, 1'b1, 1, 1'b1, 4'h2};
        tbl[17] = '{1'b1, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 4'h0};
        tbl[18] = '{1'b1, 4'h5, 4'h0, 1'b1, 1'b1, 1'b0, 2, 1'b1, 4'h4};
        tbl[19] = '{1'b0, 4'h5, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[20] = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'h0};
        tbl[21] = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 4'h1};

        drive(1'b0, 4'hF, 4'h0, 1'b1, 0, 0, 0, 0);
        tick();
        for (int v = 0; v < 22; v++) begin
            drive(tbl[v].rst_n, tbl[v].vld, tbl[v].lst, tbl[v].rdy, 0, 0, 0, 0);
            #2;
            chk_out($sformatf("vec%0d", v), tbl[v].e_mv, tbl[v].e_ml, tbl[v].e_tid,
                    tbl[v].e_act, tbl[v].e_sr, dat(tbl[v].e_tid, 0));
            tick();
        end

        // all four stream 3-beat packets back to back: order 0,1,2,3,0 with one bubble each
        do_reset();
        beats = '{0, 0, 0, 0};
        for (int c = 0; c < 21; c++) begin
            for (int i = 0; i < N; i++) lst[i] = (beats[i] == 2);
            drive(1'b1, 4'hF, lst, 1'b1, beats[0], beats[1], beats[2], beats[3]);
            #2;
            if (c == 0) chk_out("rr c0", 1'b0, 1'b0, 0, 1'b0, 4'h0, '0);
            else if ((c - 1) % 4 < 3)
                chk_out($sformatf("rr c%0d", c), 1'b1, ((c - 1) % 4) == 2, ((c - 1) / 4) % 4, 1'b1,
                        4'(1 << (((c - 1) / 4) % 4)), dat(((c - 1) / 4) % 4, (c - 1) % 4));
            else chk_out($sformatf("rr c%0d", c), 1'b0, 1'b0, ((c - 1) / 4) % 4, 1'b0, 4'h0, '0);
            for (int i = 0; i < N; i++) if (axis.s_axis_tready[i]) beats[i] = (beats[i] + 1) % 3;
            tick();
        end

        // requester 2 four-beat packet under a toggling tready while requester 1 waits
        do_reset();
        drive(1'b1, 4'h4, 4'h0, 1'b1, 0, 0, 0, 0);
        #2;
        chk_out("stall idle", 1'b0, 1'b0, 0, 1'b0, 4'h0, '0);
        tick();
        b2 = 0;
        k = 0;
        while (b2 < 4 && k < 12) begin
            rdy = (k % 2 == 0);
            drive(1'b1, 4'h6, (b2 == 3) ? 4'h4 : 4'h0, rdy, 0, 0, b2, 0);
            #2;
            chk_out($sformatf("stall k%0d", k), 1'b1, b2 == 3, 2, 1'b1, rdy ? 4'h4 : 4'h0, dat(2, b2));
            if (rdy) b2++;
            k++;
            tick();
        end
        chk("stall packet completed", 64'(b2), 64'd4);
        drive(1'b1, 4'h2, 4'h0, 1'b1, 0, 0, 0, 0);
        #2;
        chk_out("stall bubble", 1'b0, 1'b0, 2, 1'b0, 4'h0, '0);
        tick();
        drive(1'b1, 4'h2, 4'h0, 1'b1, 0, 0, 0, 0);
        #2;
        chk_out("stall next grant", 1'b1, 1'b0, 1, 1'b1, 4'h2, dat(1, 0));
        tick();

        // randomized traffic against the behavioural model
        do_reset();
        owner = -1;
        ptr = 0;
        lastg = 0;
        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 127) != 0);
            vld   = 4'($urandom);
            lst   = 4'($urandom) & 4'($urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) beats[i] = int'($urandom_range(0, 1000));
            drive(rst_n, vld, lst, rdy, beats[0], beats[1], beats[2], beats[3]);
            if (!rst_n) begin
                owner = -1;
                ptr = 0;
                lastg = 0;
            end
            emv = (owner >= 0) && vld[owner];
            eml = (owner >= 0) && lst[owner];
            esr = (owner >= 0 && rdy) ? 4'(1 << owner) : 4'h0;
            #2;
            chk_out($sformatf("rand c%0d", c), emv, eml, lastg, owner >= 0, esr,
                    dat(lastg, beats[lastg]));
            if (rst_n) begin
                if (owner < 0) begin
                    for (int j = 0; j < N; j++)
                        if (owner < 0 && vld[(ptr + j) % N]) begin
                            owner = (ptr + j) % N;
                            lastg = owner;
                        end
                end else if (emv && rdy && eml) begin
                    ptr = (owner + 1) % N;
                    owner = -1;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_rr_packet_arbiter.md
Name: axis_rr_packet_arbiter

Overview:
- Round-robin, packet-locked N:1 AXI-Stream arbiter placed in front of the wide-to-narrow stream downsizer.
- Lets NUM_REQ wide producers share one downsizer.
- A grant is held from the first beat to the tlast beat of a packet, so packets are never interleaved.
- Outputs the granted index on m_axis_tid so downstream logic can route narrow beats back per source.

Parameters:
- NUM_REQ, 4, number of requesting slave streams; legal range 2..16.
- DATA_WIDTH, 64, tdata width of every slave port and of the master port.
- ID_WIDTH, $clog2(NUM_REQ), width of m_axis_tid and grant_idx; derived, not overridden.

Ports:
- aclk  input  1  single clock for all logic.
- areset  input  1  asynchronous reset, active-low (asserted when 0).
- s_axis_tdata  input  NUM_REQ*DATA_WIDTH  requester i occupies bits [DATA_WIDTH*i +: DATA_WIDTH].
- s_axis_tvalid  input  NUM_REQ  per-requester valid.
- s_axis_tlast  input  NUM_REQ  per-requester end-of-packet.
- s_axis_tready  output  NUM_REQ  per-requester ready.
- m_axis_tdata  output  DATA_WIDTH  granted requester's data.
- m_axis_tvalid  output  1  granted requester's valid.
- m_axis_tlast  output  1  granted requester's last.
- m_axis_tid  output  ID_WIDTH  index of granted requester.
- m_axis_tready  input  1  downstream (downsizer) ready.
- grant_active  output  1  high while in LOCKED state.
- grant_idx  output  ID_WIDTH  registered current grant.

Behaviour:
- State machine: IDLE and LOCKED. Registers: state, grant_idx, rr_ptr (ID_WIDTH bits).
- Reset (areset low, asynchronous):
  - state=IDLE, grant_idx=0, rr_ptr=0.
  - All s_axis_tready=0, m_axis_tvalid=0, grant_active=0.
  - Release is sampled on aclk.
- IDLE:
  - m_axis_tvalid=0 and s_axis_tready=0 for every requester. No data passes while IDLE.
  - If any s_axis_tvalid is high, select the first requester i with tvalid=1, searching cyclically from rr_ptr (rr_ptr, rr_ptr+1, ... mod NUM_REQ).
  - On the next edge: grant_idx<=i, state<=LOCKED.
  - Arbitration latency is exactly 1 cycle from tvalid to the first forwarded beat.
- LOCKED:
  - Combinational forwarding: m_axis_tdata/tvalid/tlast = s_axis_*[grant_idx]; m_axis_tid=grant_idx.
  - s_axis_tready[grant_idx]=m_axis_tready; all other s_axis_tready=0.
  - No added latency and no buffering.
- Packet end: a handshake (m_axis_tvalid & m_axis_tready) with m_axis_tlast=1 causes, on that edge:
  - state<=IDLE;
  - rr_ptr<=grant_idx+1, wrapping to 0 when grant_idx=NUM_REQ-1.
- Inter-packet bubble: exactly one IDLE cycle between packets, even when the same or another requester is waiting.
- Fairness: a requester continuously asserting tvalid is granted within NUM_REQ-1 packets of other requesters.
- Granted requester drops tvalid mid-packet: the grant is held, m_axis_tvalid follows it low, and there is no re-arbitration until tlast is handshaken.
- Non-granted requesters: their tvalid/tdata changes have no effect while LOCKED.
- m_axis_tready low: stalls only the granted requester; the state is unchanged.
- Single-beat packet (tlast on the first beat): one LOCKED cycle if tready=1, then IDLE.
- Reset mid-packet: the packet is abandoned and the outputs drop to reset values immediately (asynchronous).
- No requests: stays in IDLE; rr_ptr is unchanged.

Test Plan:
- Reset with all tvalid=1 → all s_axis_tready=0, m_axis_tvalid=0, grant_active=0. After release, the first grant is index 0 at cycle 1 (m_axis_tid=0).
- Requesters 0..3 each continuously send 3-beat packets with m_axis_tready=1:
  - grant order is 0,1,2,3,0;
  - each packet is 3 consecutive beats followed by one bubble cycle;
  - m_axis_tid matches the source on every beat.
- Requester 2 sends a 4-beat packet with m_axis_tready toggling 1,0,1,0 while requester 1 also requests:
  - no beat from requester 1 appears before requester 2's tlast handshake;
  - s_axis_tready[1] stays 0 throughout.
- Only requester 3 requests with rr_ptr=0; then requesters 0 and 3 request:
  - first grant is 3, rr_ptr becomes 0;
  - next grant is 0, not 3.
- Granted requester 1 drops tvalid for 2 cycles mid-packet while requester 0 is valid → m_axis_tvalid=0 for those 2 cycles, grant_idx stays 1, and requester 1 resumes and completes.
- areset asserted on the 2nd beat of a 5-beat packet → outputs go to reset values immediately. After release, arbitration restarts from rr_ptr=0.
